// File: rtl/y86_regfile_wb_pipe_pkg.sv
// y86_regfile_wb_pipe_pkg
//   Shared Y86-64 constants, the decode-table helper and the writeback
//   pipeline entry type used by the register-file block and its scoreboard.
package y86_regfile_wb_pipe_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVQ  = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } dec_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] icode;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } sb_entry_t;

  // Raw decode table; out-of-range specifiers are squashed by the caller.
  function automatic dec_t decode(input logic [3:0] icode,
                                  input logic [3:0] ra,
                                  input logic [3:0] rb);
    dec_t d;
    d = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
    case (icode)
      I_CMOVQ:  begin d.src_a = ra;  d.src_b = rb;  d.dst_e = rb;  end
      I_IRMOVQ: begin d.dst_e = rb; end
      I_RMMOVQ: begin d.src_a = ra;  d.src_b = rb;  end
      I_MRMOVQ: begin d.src_b = rb;  d.dst_m = ra;  end
      I_OPQ:    begin d.src_a = ra;  d.src_b = rb;  d.dst_e = rb;  end
      I_CALL:   begin d.src_b = RSP; d.dst_e = RSP; end
      I_RET:    begin d.src_a = RSP; d.src_b = RSP; d.dst_e = RSP; end
      I_PUSHQ:  begin d.src_a = ra;  d.src_b = RSP; d.dst_e = RSP; end
      I_POPQ:   begin d.src_a = RSP; d.src_b = RSP; d.dst_e = RSP; d.dst_m = ra; end
      default:  ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/y86_regfile_wb_pipe_wb_scoreboard.sv
// y86_wb_scoreboard
//   WB_LAT-deep shift register of in-flight destinations. Entry 0 is the
//   instruction accepted on the previous edge; entry WB_LAT-1 is the
//   writeback stage. Raises hazard_o when a source register is still owed
//   a write by an entry in stages 0..WB_LAT-2.
// Ports
//   clk_i, rst_n_i      clock / async active-low reset
//   push_i              instruction accepted this cycle
//   push_icode_i        icode of the accepted instruction
//   push_dst_e_i/_m_i   decoded destinations (RNONE when absent)
//   src_a_i, src_b_i    sources of the instruction waiting in decode
//   hazard_o            read-after-write hazard against non-writeback stages
//   wb_o                writeback-stage entry
module y86_wb_scoreboard
  import y86_regfile_wb_pipe_pkg::*;
#(
  parameter int WB_LAT = 3
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       push_i,
  input  logic [3:0] push_icode_i,
  input  logic [3:0] push_dst_e_i,
  input  logic [3:0] push_dst_m_i,
  input  logic [3:0] src_a_i,
  input  logic [3:0] src_b_i,
  output logic       hazard_o,
  output sb_entry_t  wb_o
);

  localparam sb_entry_t BUBBLE = '{valid: 1'b0, icode: I_NOP, dst_e: RNONE, dst_m: RNONE};

  sb_entry_t pipe_q [WB_LAT];
  sb_entry_t head_d;

  always_comb begin
    head_d = BUBBLE;
    if (push_i) begin
      head_d = '{valid: 1'b1, icode: push_icode_i, dst_e: push_dst_e_i, dst_m: push_dst_m_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < WB_LAT; i++) pipe_q[i] <= BUBBLE;
    end else begin
      pipe_q[0] <= head_d;
      for (int i = 1; i < WB_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Cmov entries keep their dst_e here whatever cnd will be: the condition
  // is only known in writeback, so the reader must wait for it.
  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < WB_LAT - 1; i++) begin
      if (pipe_q[i].valid) begin
        if (src_a_i != RNONE && (src_a_i == pipe_q[i].dst_e || src_a_i == pipe_q[i].dst_m))
          hazard_o = 1'b1;
        if (src_b_i != RNONE && (src_b_i == pipe_q[i].dst_e || src_b_i == pipe_q[i].dst_m))
          hazard_o = 1'b1;
      end
    end
  end

  assign wb_o = pipe_q[WB_LAT-1];

endmodule

// File: rtl/y86_regfile_wb_pipe.sv
// y86_regfile_wb_pipe
//   Y86-64 decode / register-file stage. Decodes sources and destinations,
//   reads operands (with same-cycle writeback bypass), stalls on hazards
//   reported by the writeback scoreboard and retires valE/valM WB_LAT cycles
//   after accept.
// Ports
//   clk_i, rst_n_i            clock / async active-low reset
//   dec_valid_i, dec_ready_o  decode handshake
//   icode_i, rA_i, rB_i       instruction fields
//   out_valid_o               one-cycle pulse after accept
//   valA_o, valB_o            registered operands
//   dstE_o, dstM_o            registered decoded destinations
//   wb_valid_o                an instruction is in writeback
//   valE_i, valM_i, cnd_i     writeback data and cmov condition
//   halted_o                  sticky, set once HALT is accepted
module y86_regfile_wb_pipe
  import y86_regfile_wb_pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int WB_LAT = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              dec_valid_i,
  output logic              dec_ready_o,
  input  logic [3:0]        icode_i,
  input  logic [3:0]        rA_i,
  input  logic [3:0]        rB_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] valA_o,
  output logic [DATA_W-1:0] valB_o,
  output logic [3:0]        dstE_o,
  output logic [3:0]        dstM_o,
  output logic              wb_valid_o,
  input  logic [DATA_W-1:0] valE_i,
  input  logic [DATA_W-1:0] valM_i,
  input  logic              cnd_i,
  output logic              halted_o
);

  function automatic logic [3:0] squash(input logic [3:0] r);
    if (r != RNONE && int'(r) >= NREG) return RNONE;
    return r;
  endfunction

  dec_t              dec_raw, dec;
  logic              hazard;
  logic              accept;
  sb_entry_t         wb;
  logic [3:0]        wb_dst_e;
  logic [3:0]        src [2];
  logic [DATA_W-1:0] rd  [2];

  logic [DATA_W-1:0] regs_q [NREG];
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] val_a_q, val_a_d, val_b_q, val_b_d;
  logic [3:0]        dst_e_q, dst_e_d, dst_m_q, dst_m_d;
  logic              halted_q, halted_d;

  always_comb begin
    dec_raw   = decode(icode_i, rA_i, rB_i);
    dec.src_a = squash(dec_raw.src_a);
    dec.src_b = squash(dec_raw.src_b);
    dec.dst_e = squash(dec_raw.dst_e);
    dec.dst_m = squash(dec_raw.dst_m);
  end

  y86_wb_scoreboard #(.WB_LAT(WB_LAT)) u_sb (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .push_i       (accept),
    .push_icode_i (icode_i),
    .push_dst_e_i (dec.dst_e),
    .push_dst_m_i (dec.dst_m),
    .src_a_i      (dec.src_a),
    .src_b_i      (dec.src_b),
    .hazard_o     (hazard),
    .wb_o         (wb)
  );

  assign dec_ready_o = !halted_q && !hazard;
  assign accept      = dec_valid_i && dec_ready_o;
  assign wb_valid_o  = wb.valid;

  // A not-taken cmov retires without touching its destination.
  assign wb_dst_e = (wb.icode == I_CMOVQ && !cnd_i) ? RNONE : wb.dst_e;

  assign src[0] = dec.src_a;
  assign src[1] = dec.src_b;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rd[k] = '0;
      if (src[k] != RNONE) begin
        if (wb.valid && src[k] == wb.dst_m)      rd[k] = valM_i;
        else if (wb.valid && src[k] == wb_dst_e) rd[k] = valE_i;
        else                                     rd[k] = regs_q[src[k]];
      end
    end
  end

  // Both writes are NBAs to the same array; the M write is last so it wins
  // when dst_e == dst_m (popq %rsp).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb.valid) begin
      if (wb_dst_e != RNONE) regs_q[wb_dst_e] <= valE_i;
      if (wb.dst_m != RNONE) regs_q[wb.dst_m] <= valM_i;
    end
  end

  always_comb begin
    out_valid_d = accept;
    val_a_d     = val_a_q;
    val_b_d     = val_b_q;
    dst_e_d     = dst_e_q;
    dst_m_d     = dst_m_q;
    halted_d    = halted_q;
    if (accept) begin
      val_a_d = rd[0];
      val_b_d = rd[1];
      dst_e_d = dec.dst_e;
      dst_m_d = dec.dst_m;
      if (icode_i == I_HALT) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      val_a_q     <= '0;
      val_b_q     <= '0;
      dst_e_q     <= RNONE;
      dst_m_q     <= RNONE;
      halted_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      val_a_q     <= val_a_d;
      val_b_q     <= val_b_d;
      dst_e_q     <= dst_e_d;
      dst_m_q     <= dst_m_d;
      halted_q    <= halted_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign valA_o      = val_a_q;
  assign valB_o      = val_b_q;
  assign dstE_o      = dst_e_q;
  assign dstM_o      = dst_m_q;
  assign halted_o    = halted_q;

endmodule
